// File: rtl/score_display.sv
// score_display: BCD score/high-score keeper with 7-segment glyph renderer.
// Ports: clk, rst (async, active-high); score_inc, score_clr, game_over pulses;
//   show_hi selects the displayed value; frame_tick drives the optional flash timer;
//   i_hpos/i_vpos pixel position; o_score/o_hi_score BCD values; o_color registered pixel.
// Optional macro SCORE_FLASH_EN: blink the score for 64 frames after each 100 crossing.
module score_display #(
    parameter int DIGITS      = 5,
    parameter int CONV        = 0,
    parameter int X_ORIGIN    = 0,
    parameter int Y_ORIGIN    = 1,
    parameter int DIGIT_PITCH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  score_inc,
    input  logic                  score_clr,
    input  logic                  game_over,
    input  logic                  show_hi,
    input  logic                  frame_tick,
    input  logic [9-CONV:0]       i_hpos,
    input  logic [9-CONV:0]       i_vpos,
    output logic [4*DIGITS-1:0]   o_score,
    output logic [4*DIGITS-1:0]   o_hi_score,
    output logic                  o_color
);

    localparam int W = 10 - CONV;

    logic [4*DIGITS-1:0] score_q;
    logic [4*DIGITS-1:0] hi_q;
    logic [4*DIGITS-1:0] score_nx;
    logic                all_nine;
    logic                carry;

    // Segment bits: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h67;
            default: glyph = 7'h00;
        endcase
    endfunction

    function automatic logic seg_on(input logic [6:0] s,
                                    input logic [1:0] x,
                                    input logic [2:0] y);
        seg_on = (s[0] && y == 3'd0)
              || (s[1] && y < 3'd3 && x == 2'd3)
              || (s[2] && y > 3'd3 && x == 2'd3)
              || (s[3] && y == 3'd6)
              || (s[4] && y > 3'd3 && x == 2'd0)
              || (s[5] && y < 3'd3 && x == 2'd0)
              || (s[6] && y == 3'd3);
    endfunction

    // Ripple BCD increment; all_nine flags the saturation point.
    always_comb begin
        score_nx = score_q;
        carry    = 1'b1;
        all_nine = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (score_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_nx[4*i +: 4] = 4'd0;
                end else begin
                    score_nx[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q <= '0;
            hi_q    <= '0;
        end else begin
            if (score_clr)
                score_q <= '0;
            else if (score_inc && !all_nine)
                score_q <= score_nx;
            // Compares against the value before this cycle's inc/clr.
            if (game_over && score_q > hi_q)
                hi_q <= score_q;
        end
    end

    assign o_score    = score_q;
    assign o_hi_score = hi_q;

    logic                blank;

`ifdef SCORE_FLASH_EN
    logic       flash_on;
    logic [5:0] flash_cnt;
    logic       cross;

    // Low two digits at 99 means this increment carries into the hundreds.
    assign cross = score_inc && !score_clr && !all_nine
                && score_q[7:0] == 8'h99;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_on  <= 1'b0;
            flash_cnt <= '0;
        end else if (score_clr) begin
            flash_on  <= 1'b0;
            flash_cnt <= '0;
        end else if (cross) begin
            flash_on  <= 1'b1;
            flash_cnt <= '0;
        end else if (flash_on && frame_tick) begin
            flash_cnt <= flash_cnt + 6'd1;
            if (flash_cnt == 6'd63) flash_on <= 1'b0;
        end
    end

    assign blank = flash_on && flash_cnt[3] && !show_hi;
`else
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
    assign blank = 1'b0;
`endif

    logic [4*DIGITS-1:0] disp;
    logic [W-1:0]        lx;
    logic [W-1:0]        ly;
    logic [3:0]          dig;
    logic                lead;
    logic                pix;

    always_comb begin
        disp = show_hi ? hi_q : score_q;
        ly   = i_vpos - W'(Y_ORIGIN);
        lx   = '0;
        dig  = '0;
        lead = 1'b1;
        pix  = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            dig = disp[4*(DIGITS-1-d) +: 4];
            // Leading zeros stay dark; the last digit always shows.
            if (dig != 4'd0 || d == DIGITS - 1) lead = 1'b0;
            // Wrapping subtraction pushes left/above pixels out of the box.
            lx = i_hpos - W'(X_ORIGIN + d * DIGIT_PITCH);
            if (!lead && lx < W'(4) && ly < W'(7))
                pix = pix | seg_on(glyph(dig), lx[1:0], ly[2:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_color <= 1'b0;
        else     o_color <= pix && !blank;
    end

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed self-checking bench for score_display.
// Second small instance (DIGITS=2) exercises saturation in few cycles.
module tb_score_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        score_inc = 1'b0;
    logic        score_clr = 1'b0;
    logic        game_over = 1'b0;
    logic        show_hi = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  hpos = '0;
    logic [9:0]  vpos = '0;
    logic [19:0] o_score;
    logic [19:0] o_hi_score;
    logic        o_color;

    logic        inc2 = 1'b0;
    logic [7:0]  s2;
    logic [7:0]  h2;
    logic        c2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    score_display dut (
        .clk(clk), .rst(rst),
        .score_inc(score_inc), .score_clr(score_clr),
        .game_over(game_over), .show_hi(show_hi),
        .frame_tick(frame_tick),
        .i_hpos(hpos), .i_vpos(vpos),
        .o_score(o_score), .o_hi_score(o_hi_score),
        .o_color(o_color)
    );

    score_display #(.DIGITS(2)) dut2 (
        .clk(clk), .rst(rst),
        .score_inc(inc2), .score_clr(1'b0),
        .game_over(1'b0), .show_hi(1'b0),
        .frame_tick(1'b0),
        .i_hpos(hpos), .i_vpos(vpos),
        .o_score(s2), .o_hi_score(h2),
        .o_color(c2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic inc_n(input int n);
        for (int i = 0; i < n; i++) begin
            score_inc = 1'b1;
            cyc();
            score_inc = 1'b0;
        end
    endtask

    task automatic clr();
        score_clr = 1'b1;
        cyc();
        score_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_tests++;
        if (o_score !== 20'h0 || o_hi_score !== 20'h0 || o_color !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: score=%h hi=%h color=%b want 0/0/0",
                     o_score, o_hi_score, o_color);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_count37();
        int px[6] = '{15, 20, 20, 0, 10, 18};
        int py[6] = '{1, 1, 7, 1, 1, 2};
        logic ex[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        inc_n(37);
        n_tests++;
        if (o_score !== 20'h00037) begin
            n_fail++;
            $display("FAIL count37: score=%h want 00037", o_score);
        end
        for (int i = 0; i < 6; i++) begin
            hpos = 10'(px[i]);
            vpos = 10'(py[i]);
            cyc();
            n_tests++;
            if (o_color !== ex[i]) begin
                n_fail++;
                $display("FAIL count37_pix(%0d,%0d): color=%b want %b",
                         px[i], py[i], o_color, ex[i]);
            end
        end
    endtask

    task automatic test_zero_blank();
        int px[6] = '{20, 20, 21, 0, 20, 1023};
        int py[6] = '{1, 4, 2, 1, 0, 1};
        logic ex[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        clr();
        n_tests++;
        if (o_score !== 20'h0) begin
            n_fail++;
            $display("FAIL zero_score: score=%h want 00000", o_score);
        end
        for (int i = 0; i < 6; i++) begin
            hpos = 10'(px[i]);
            vpos = 10'(py[i]);
            cyc();
            n_tests++;
            if (o_color !== ex[i]) begin
                n_fail++;
                $display("FAIL zero_pix(%0d,%0d): color=%b want %b",
                         px[i], py[i], o_color, ex[i]);
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 101; i++) begin
            inc2 = 1'b1;
            cyc();
            inc2 = 1'b0;
        end
        n_tests++;
        if (s2 !== 8'h99 || h2 !== 8'h00) begin
            n_fail++;
            $display("FAIL saturate: score=%h hi=%h want 99/00", s2, h2);
        end
        hpos = 10'd5;
        vpos = 10'd4;
        cyc();
        n_tests++;
        if (c2 !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate_pix: color=%b want 1", c2);
        end
    endtask

    task automatic test_high_score();
        int px[4] = '{13, 10, 5, 15};
        int py[4] = '{2, 1, 1, 1};
        logic ex_hi[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic ex_sc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        clr();
        inc_n(120);
        game_over = 1'b1;
        cyc();
        game_over = 1'b0;
        n_tests++;
        if (o_hi_score !== 20'h00120) begin
            n_fail++;
            $display("FAIL hi_commit: hi=%h want 00120", o_hi_score);
        end
        game_over = 1'b1;
        score_inc = 1'b1;
        cyc();
        game_over = 1'b0;
        score_inc = 1'b0;
        n_tests++;
        if (o_hi_score !== 20'h00120 || o_score !== 20'h00121) begin
            n_fail++;
            $display("FAIL hi_pre_update: hi=%h score=%h want 00120/00121",
                     o_hi_score, o_score);
        end
        clr();
        inc_n(50);
        game_over = 1'b1;
        cyc();
        game_over = 1'b0;
        n_tests++;
        if (o_hi_score !== 20'h00120 || o_score !== 20'h00050) begin
            n_fail++;
            $display("FAIL hi_keep: hi=%h score=%h want 00120/00050",
                     o_hi_score, o_score);
        end
        for (int i = 0; i < 4; i++) begin
            show_hi = 1'b1;
            hpos = 10'(px[i]);
            vpos = 10'(py[i]);
            cyc();
            n_tests++;
            if (o_color !== ex_hi[i]) begin
                n_fail++;
                $display("FAIL hi_pix(%0d,%0d): color=%b want %b",
                         px[i], py[i], o_color, ex_hi[i]);
            end
            show_hi = 1'b0;
            cyc();
            n_tests++;
            if (o_color !== ex_sc[i]) begin
                n_fail++;
                $display("FAIL score_pix(%0d,%0d): color=%b want %b",
                         px[i], py[i], o_color, ex_sc[i]);
            end
        end
    endtask

    task automatic test_inc_clr();
        score_inc = 1'b1;
        score_clr = 1'b1;
        cyc();
        score_inc = 1'b0;
        score_clr = 1'b0;
        n_tests++;
        if (o_score !== 20'h0) begin
            n_fail++;
            $display("FAIL inc_clr: score=%h want 00000", o_score);
        end
    endtask

    task automatic test_rst_mid();
        hpos = 10'd20;
        vpos = 10'd1;
        cyc();
        n_tests++;
        if (o_color !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: color=%b want 1", o_color);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (o_color !== 1'b0 || o_hi_score !== 20'h0) begin
            n_fail++;
            $display("FAIL rst_async: color=%b hi=%h want 0/00000",
                     o_color, o_hi_score);
        end
        cyc();
        n_tests++;
        if (o_color !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold: color=%b want 0", o_color);
        end
        rst = 1'b0;
        cyc();
        n_tests++;
        if (o_color !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_resume: color=%b want 1", o_color);
        end
    endtask

`ifdef SCORE_FLASH_EN
    task automatic test_flash();
        logic exp;
        clr();
        inc_n(100);
        hpos = 10'd13;
        vpos = 10'd2;
        cyc();
        n_tests++;
        if (o_color !== 1'b1 || o_score !== 20'h00100) begin
            n_fail++;
            $display("FAIL flash_start: color=%b score=%h want 1/00100",
                     o_color, o_score);
        end
        for (int k = 1; k <= 72; k++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
            exp = !(k < 64 && ((k % 16) >= 8));
            n_tests++;
            if (o_color !== exp) begin
                n_fail++;
                $display("FAIL flash_tick%0d: color=%b want %b", k, o_color, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_count37();
        test_zero_blank();
        test_saturate();
        test_high_score();
        test_inc_clr();
`ifdef SCORE_FLASH_EN
        test_flash();
        clr();
`endif
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
